dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 (core load/store unit) and port 1 (debug/DMA loader).
- Performs round-robin arbitration, allows one outstanding read, returns read data with a valid strobe, and rejects out-of-range or misaligned addresses without touching memory.
- Sits between the pipeline MEM stage / debug port and data_mem.

---
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 tb/tb_dmem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between
// the core LSU (port 0) and the debug/DMA loader (port 1).
//
// Ports:
//   clk, rst                    : clock, async active-high reset
//   pX_req/we/addr/wdata        : requests from port X
//   pX_gnt                      : request accepted this cycle
//   pX_rvalid, pX_err           : registered read-valid / reject pulses
//   rdata                       : shared read data, qualified by pX_rvalid
//   mem_addr/read/write/wdata   : command to data_mem
//   mem_rdata                   : data_mem read data, one cycle after mem_read
module dmem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int ADDR_MAX = 1500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req,
  input  logic             p0_we,
  input  logic [WIDTH-1:0] p0_addr,
  input  logic [WIDTH-1:0] p0_wdata,
  output logic             p0_gnt,
  output logic             p0_rvalid,
  output logic             p0_err,
  input  logic             p1_req,
  input  logic             p1_we,
  input  logic [WIDTH-1:0] p1_addr,
  input  logic [WIDTH-1:0] p1_wdata,
  output logic             p1_gnt,
  output logic             p1_rvalid,
  output logic             p1_err,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_e;

  localparam logic [WIDTH-1:0] AMAX = WIDTH'(ADDR_MAX);

  state_e           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [1:0]       err_q, err_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic             win0, win1, gnt_any;
  logic             sel_we, legal;
  logic [WIDTH-1:0] sel_addr, sel_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      rvalid_q  <= '0;
      err_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  always_comb begin
    win0      = 1'b0;
    win1      = 1'b0;
    state_d   = state_q;
    rr_last_d = rr_last_q;
    rvalid_d  = '0;
    err_d     = '0;
    rdata_d   = rdata_q;

    // Grants are gated by rst so the memory sees nothing during reset.
    if (!rst && state_q == IDLE) begin
      win0 = p0_req && (!p1_req || rr_last_q);
      win1 = p1_req && (!p0_req || !rr_last_q);
    end
    gnt_any = win0 || win1;

    sel_we    = win1 ? p1_we    : p0_we;
    sel_addr  = win1 ? p1_addr  : p0_addr;
    sel_wdata = win1 ? p1_wdata : p0_wdata;
    legal     = (sel_addr <= AMAX) && (sel_addr[1:0] == 2'b00);

    p0_gnt    = win0;
    p1_gnt    = win1;
    mem_addr  = gnt_any ? sel_addr  : '0;
    mem_wdata = gnt_any ? sel_wdata : '0;
    mem_read  = gnt_any && legal && !sel_we;
    mem_write = gnt_any && legal &&  sel_we;

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          rr_last_d = win1;
          if (!sel_we)
            rvalid_d = {win1, win0};
          if (!legal) begin
            // Rejected reads answer next cycle with zero data.
            err_d = {win1, win0};
            if (!sel_we)
              rdata_d = '0;
          end else if (!sel_we) begin
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        state_d = IDLE;
        rdata_d = mem_rdata;
      end
    endcase
  end

  // Legal read data comes straight from memory in the response cycle,
  // then is held in rdata_q until the next response.
  assign rdata     = (state_q == RD_WAIT) ? mem_rdata : rdata_q;
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_err    = err_q[0];
  assign p1_err    = err_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed vectors push expected
// read responses, a negedge monitor pops and compares them.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 0, p0_we = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0;
  logic        p1_req = 0, p1_we = 0;
  logic [31:0] p1_addr = 0, p1_wdata = 0;
  logic        p0_gnt, p0_rvalid, p0_err;
  logic        p1_gnt, p1_rvalid, p1_err;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata = 0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          port;
    logic [31:0] data;
    bit          err;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mem [0:2047];

  always #5 clk = ~clk;

  dmem_arbiter #(.WIDTH(32), .ADDR_MAX(1500)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_err(p1_err),
    .rdata(rdata),
    .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory model: synchronous read, data valid the cycle after mem_read.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[10:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr[10:0]];
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic push(input bit port, input logic [31:0] d,
                      input bit e);
    exp_t x;
    x.port = port;
    x.data = d;
    x.err  = e;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (p0_rvalid || p1_rvalid)) begin
      exp_t x;
      if (p0_rvalid && p1_rvalid) begin
        chk("mon_both_rvalid", 1, 0);
      end else if (sb.size() == 0) begin
        chk("mon_unexpected_rvalid", {31'd0, p1_rvalid}, 32'hFFFF_FFFF);
      end else begin
        x = sb.pop_front();
        chk("mon_port", {31'd0, p1_rvalid}, {31'd0, x.port});
        chk("mon_rdata", rdata, x.data);
        chk("mon_err", {31'd0, (x.port ? p1_err : p0_err)},
            {31'd0, x.err});
      end
    end
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[1000] = 32'h08;
    mem[1004] = 32'h10;
    mem[1500] = 32'h55;

    // Reset with both requests asserted: outputs must stay zero.
    p0_req = 1; p0_addr = 1000;
    p1_req = 1; p1_addr = 1004;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_p1_gnt", p1_gnt, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", {p0_rvalid, p1_rvalid, p0_err, p1_err}, 0);

    // Tie right after reset: p0 first, p1 two cycles later.
    step();
    rst = 0;
    push(0, 32'h08, 0);
    push(1, 32'h10, 0);
    @(negedge clk);
    chk("tie_p0_gnt", p0_gnt, 1);
    chk("tie_p1_gnt", p1_gnt, 0);
    chk("tie_mem_read", mem_read, 1);
    chk("tie_mem_addr", mem_addr, 1000);
    step();
    p0_req = 0;
    @(negedge clk);
    chk("rdwait_p1_gnt", p1_gnt, 0);
    chk("rdwait_mem_read", mem_read, 0);
    step();
    @(negedge clk);
    chk("tie2_p1_gnt", p1_gnt, 1);
    chk("tie2_mem_addr", mem_addr, 1004);
    step();
    p1_req = 0;
    @(negedge clk);
    step();

    // Port 0 read alone.
    p0_req = 1; p0_we = 0; p0_addr = 1000;
    push(0, 32'h08, 0);
    @(negedge clk);
    chk("solo_p0_gnt", p0_gnt, 1);
    chk("solo_mem_read", mem_read, 1);
    chk("solo_p1_gnt", p1_gnt, 0);
    step();
    p0_req = 0;
    @(negedge clk);
    chk("solo_p1_quiet", {p1_rvalid, p1_err}, 0);
    step();

    // Port 1 back-to-back writes, then read back through port 0.
    p1_req = 1; p1_we = 1; p1_addr = 1040; p1_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("wr_p1_gnt%0d", i), p1_gnt, 1);
      chk($sformatf("wr_mem_write%0d", i), mem_write, 1);
      step();
    end
    p1_req = 0; p1_we = 0;
    p0_req = 1; p0_we = 0; p0_addr = 1040;
    push(0, 32'hDEADBEEF, 0);
    @(negedge clk);
    chk("rb_p0_gnt", p0_gnt, 1);
    step();
    p0_req = 0;
    @(negedge clk);
    step();

    // Both write continuously; last grant was p0, so p1 leads.
    p0_req = 1; p0_we = 1; p0_addr = 1100; p0_wdata = 32'h11;
    p1_req = 1; p1_we = 1; p1_addr = 1104; p1_wdata = 32'h22;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("alt_p0_gnt%0d", i), p0_gnt, (i % 2 == 1));
      chk($sformatf("alt_p1_gnt%0d", i), p1_gnt, (i % 2 == 0));
      step();
    end
    p0_req = 0; p0_we = 0;
    p1_req = 0; p1_we = 0;

    // Illegal reads back to back, then the boundary address 1500.
    p0_req = 1; p0_addr = 1502;
    push(0, 32'h0, 1);
    @(negedge clk);
    chk("bad1502_gnt", p0_gnt, 1);
    chk("bad1502_mem", {mem_read, mem_write}, 0);
    step();
    p0_addr = 1001;
    push(0, 32'h0, 1);
    @(negedge clk);
    chk("bad1001_gnt", p0_gnt, 1);
    chk("bad1001_mem", {mem_read, mem_write}, 0);
    step();
    p0_addr = 1500;
    push(0, 32'h55, 0);
    @(negedge clk);
    chk("ok1500_gnt", p0_gnt, 1);
    chk("ok1500_mem_read", mem_read, 1);
    step();
    p0_req = 0;
    @(negedge clk);
    step();

    // Illegal write: error pulse without a read response.
    p0_req = 1; p0_we = 1; p0_addr = 1501;
    @(negedge clk);
    chk("bad1501_gnt", p0_gnt, 1);
    chk("bad1501_mem_write", mem_write, 0);
    step();
    p0_req = 0; p0_we = 0;
    @(negedge clk);
    chk("bad1501_err", p0_err, 1);
    chk("bad1501_rvalid", p0_rvalid, 0);
    step();

    // Reset during RD_WAIT drops the response; rr pointer restarts.
    p0_req = 1; p0_addr = 1000;
    @(negedge clk);
    chk("rstrd_gnt", p0_gnt, 1);
    step();
    p0_req = 0;
    #2;
    rst = 1;
    p0_req = 1; p0_we = 1; p0_addr = 1100;
    p1_req = 1; p1_we = 1; p1_addr = 1104;
    #1;
    chk("rstrd_rvalid", {p0_rvalid, p1_rvalid}, 0);
    chk("rstrd_rdata", rdata, 0);
    chk("rstrd_gnt_off", {p0_gnt, p1_gnt}, 0);
    chk("rstrd_mem_off", {mem_read, mem_write}, 0);
    step();
    rst = 0;
    @(negedge clk);
    chk("post_rst_p0_gnt", p0_gnt, 1);
    chk("post_rst_p1_gnt", p1_gnt, 0);
    step();
    p0_req = 0; p1_req = 0;
    p0_we = 0; p1_we = 0;
    repeat (3) step();

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
